sbox_layer_seq: RTL and testbench
=================================

// Module: sbox_layer_seq
// PURPOSE
//  Nibble-serial sequencer for the 2-share threshold uBlock S-box layer.
//  - Loads a shared state, then feeds one share-nibble pair per cycle into the decomposed shared S-box pipeline (F stage, then G stage).
//  - Supplies the 2 fresh guard bits per cycle from an internal LFSR.
//  - Collects the shared S-box outputs and returns the substituted shared state through a valid/ready handshake.
//  - Sits between the round datapath and the shared S-box pipeline.
// PARAMETERS
//  NIBBLES    16       nibbles per share (state width W = 4*NIBBLES)
//  SBOX_LAT   2        register latency of the external S-box pipeline (F+G), cycles, >=1
//  LFSR_SEED  16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   input state valid
//  in_ready   out  1   high only in IDLE
//  in_s0      in   W   share 0 of input state
//  in_s1      in   W   share 1 of input state
//  out_valid  out  1   substituted state valid
//  out_ready  in   1   consumer accepts result
//  out_s0     out  W   share 0 of result
//  out_s1     out  W   share 1 of result
//  sb_in0     out  4   share-0 nibble to S-box pipeline {d,c,b,a}
//  sb_in1     out  4   share-1 nibble to S-box pipeline
//  sb_guards  out  2   guard bits {rb,ra} to F stage
//  sb_out0    in   4   share-0 nibble from S-box pipeline
//  sb_out1    in   4   share-1 nibble from S-box pipeline
// BEHAVIOUR
//  - Reset (async):
//      state=IDLE, counters 0, share registers 0, out_valid=0, out_s0/out_s1=0, LFSR=LFSR_SEED.
//      in_ready=0 while rst_n is low.
//  - FSM states: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  - IDLE:
//      in_ready=1.
//      in_valid&in_ready at edge k: latch in_s0/in_s1, cnt=0, go FEED.
//  - FEED (cycles k+1 .. k+NIBBLES):
//      sb_in0 = share0 nibble cnt, sb_in1 = share1 nibble cnt, nibble 0 = bits[3:0] first.
//      cnt increments each cycle. After the cycle with cnt==NIBBLES-1, go DRAIN.
//  - Capture:
//      A SBOX_LAT-deep tag shift register marks the cycles where sb_out* is valid.
//      Nibble i is captured at the end of cycle k+1+i+SBOX_LAT into result nibble i.
//  - DRAIN: lasts SBOX_LAT cycles, until the last tag has retired; then go DONE.
//  - DONE:
//      out_valid=1 in cycle k+NIBBLES+SBOX_LAT+1; out_s* held stable.
//      out_valid&out_ready: go IDLE and deassert out_valid next cycle.
//      in_ready=0 in DONE, so there are no back-to-back accepts.
//  - Masking rules:
//      sb_in0/sb_out0 touch only share-0 registers; likewise for share 1.
//      No share-0 and share-1 value is ever combined in logic.
//      sb_in*=0 outside FEED.
//  - Guards:
//      16-bit Fibonacci LFSR with taps 16,14,13,11. It advances once per FEED cycle only.
//      sb_guards = lfsr[1:0] in every state (the value is only consumed during FEED).
//  - in_valid outside IDLE is ignored.
//  - out_ready outside DONE is ignored.
//  - rst_n low mid-FEED/DRAIN: aborts immediately; no partial result is ever presented.
// CONFIGURATION
//  SBOX_EXT_GUARDS_EN
//    defined:
//      - Adds port ext_guards (in, 2); sb_guards = ext_guards combinationally.
//      - The LFSR and LFSR_SEED are removed.
//    undefined: internal LFSR as above; port ext_guards is absent.
// TESTING
//  Bench stub: a 2-register identity delay as the S-box pipeline (SBOX_LAT=2), NIBBLES=16.
//  1. Reset, then in_s0=64'h0123456789ABCDEF, in_s1=64'hFFFF0000FFFF0000, accepted at edge k.
//     -> out_valid rises at cycle k+19; out_s0/out_s1 equal the inputs.
//  2. Same input, out_ready held low 5 cycles.
//     -> out_valid and out_s* stay stable; IDLE (in_ready=1) is reached one cycle after out_ready=1.
//  3. LFSR check, seed 16'hACE1.
//     -> first FEED cycle sb_guards=2'b01.
//     -> the sequence matches the reference LFSR model over 16 cycles; it is frozen in IDLE.
//  4. Pulse rst_n low at FEED cnt=7.
//     -> in_ready=0 during reset; out_valid never asserts.
//     -> a fresh transaction afterwards completes in 19 cycles.
//  5. Real F+G shared pipeline, random masks.
//     -> out_s0^out_s1 equals the unshared uBlock S-box of (in_s0^in_s1) for 1000 random states.
//  6. in_valid held high through FEED/DONE.
//     -> exactly one accept per transaction; the second state is accepted only after return to IDLE.

Source files
------------

// File: rtl/sbox_layer_seq.sv
// Nibble-serial sequencer for the 2-share uBlock S-box layer: feeds share nibbles to an external F+G pipeline and reassembles the result.
// Optional build macro SBOX_EXT_GUARDS_EN: guard bits come from port ext_guards instead of the internal LFSR.
module sbox_layer_seq #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 2
`ifndef SBOX_EXT_GUARDS_EN
  ,parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_s0,
  input  logic [4*NIBBLES-1:0] in_s1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_s0,
  output logic [4*NIBBLES-1:0] out_s1,
  output logic [3:0]           sb_in0,
  output logic [3:0]           sb_in1,
  output logic [1:0]           sb_guards,
  input  logic [3:0]           sb_out0,
  input  logic [3:0]           sb_out1
`ifdef SBOX_EXT_GUARDS_EN
  ,input logic [1:0]           ext_guards
`endif
);

  localparam int W    = 4 * NIBBLES;
  localparam int CMAX = (NIBBLES > SBOX_LAT) ? NIBBLES : SBOX_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_cap;
  logic [SBOX_LAT-1:0] r_tag;
  logic [W-1:0]        r_s0;
  logic [W-1:0]        r_s1;
  logic [W-1:0]        r_res0;
  logic [W-1:0]        r_res1;
  logic                w_accept;
  logic                w_feed;
  logic                w_feed_last;
  logic                w_drain_last;

  assign w_feed       = (r_state == S_FEED);
  assign w_accept     = (r_state == S_IDLE) && in_valid;
  assign w_feed_last  = w_feed && (r_cnt == CW'(NIBBLES - 1));
  assign w_drain_last = (r_state == S_DRAIN) && (r_cnt == CW'(SBOX_LAT - 1));

  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);
  assign out_s0    = r_res0;
  assign out_s1    = r_res1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_next = S_FEED;
      S_FEED:  if (w_feed_last)  w_next = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_DONE;
      S_DONE:  if (out_ready)    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Shares are selected by separate muxes so the two never meet in one gate.
  always_comb begin
    sb_in0 = 4'h0;
    sb_in1 = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (w_feed && (r_cnt == CW'(i))) begin
        sb_in0 = r_s0[4*i +: 4];
        sb_in1 = r_s1[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept || w_feed_last || w_drain_last)
        r_cnt <= '0;
      else if (w_feed || (r_state == S_DRAIN))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // The tag pipe mirrors the external S-box latency; its tail marks valid sb_out* data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag  <= '0;
      r_cap  <= '0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_res0 <= '0;
      r_res1 <= '0;
    end else begin
      r_tag <= (r_tag << 1) | SBOX_LAT'(w_feed);
      if (w_accept) begin
        r_s0  <= in_s0;
        r_s1  <= in_s1;
        r_cap <= '0;
      end else if (r_tag[SBOX_LAT-1]) begin
        r_cap <= r_cap + CW'(1);
      end
      for (int i = 0; i < NIBBLES; i++) begin
        if (r_tag[SBOX_LAT-1] && (r_cap == CW'(i))) begin
          r_res0[4*i +: 4] <= sb_out0;
          r_res1[4*i +: 4] <= sb_out1;
        end
      end
    end
  end

`ifdef SBOX_EXT_GUARDS_EN
  assign sb_guards = ext_guards;
`else
  logic [15:0] r_lfsr;
  logic        w_fb;

  // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  assign w_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign sb_guards = r_lfsr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= LFSR_SEED;
    else if (w_feed)
      r_lfsr <= {w_fb, r_lfsr[15:1]};
  end
`endif

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Bench for sbox_layer_seq: identity or masked behavioural S-box stub (2 cycles), random states, reference models.
module tb_sbox_layer_seq;

  localparam int N = 16;
  localparam int L = 2;
  localparam int W = 4 * N;
  localparam int EXP_LAT = N + L + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_s0 = '0;
  logic [W-1:0] in_s1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_s0;
  logic [W-1:0] out_s1;
  logic [3:0]   sb_in0, sb_in1, sb_out0, sb_out1;
  logic [1:0]   sb_guards;
`ifdef SBOX_EXT_GUARDS_EN
  logic [1:0]   ext_guards = 2'b00;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] SB [16] = '{4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
                          4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5};

  sbox_layer_seq #(.NIBBLES(N), .SBOX_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_s0(in_s0), .in_s1(in_s1),
    .out_valid(out_valid), .out_ready(out_ready), .out_s0(out_s0), .out_s1(out_s1),
    .sb_in0(sb_in0), .sb_in1(sb_in1), .sb_guards(sb_guards),
    .sb_out0(sb_out0), .sb_out1(sb_out1)
`ifdef SBOX_EXT_GUARDS_EN
    , .ext_guards(ext_guards)
`endif
  );

  always #5 clk = ~clk;

  // S-box pipeline stand-in: mode 0 is a pure delay, mode 1 a re-masked S-box.
  bit         sb_mode = 1'b0;
  logic [3:0] p1_0, p1_1, p2_0, p2_1, m;
  always @(posedge clk) begin
    if (sb_mode) begin
      m = 4'($urandom);
      p1_0 <= SB[sb_in0 ^ sb_in1] ^ m;
      p1_1 <= m;
    end else begin
      p1_0 <= sb_in0;
      p1_1 <= sb_in1;
    end
    p2_0 <= p1_0;
    p2_1 <= p1_1;
  end
  assign sb_out0 = p2_0;
  assign sb_out1 = p2_1;

  function automatic logic [W-1:0] sbox_state(input logic [W-1:0] x);
    logic [W-1:0] y = '0;
    for (int i = 0; i < N; i++) y[4*i +: 4] = SB[x[4*i +: 4]];
    return y;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v = int'(s);
    int b = ((v >> (16-16)) ^ (v >> (16-14)) ^ (v >> (16-13)) ^ (v >> (16-11))) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [W-1:0] rnd_state();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Accepts one state and returns the cycle count to out_valid (stops with out_valid high).
  task automatic do_txn(input logic [W-1:0] s0, input logic [W-1:0] s1,
                        output int lat, output logic [W-1:0] r0, output logic [W-1:0] r1);
    int w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    in_s0 = s0;
    in_s1 = s1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    r0 = out_s0;
    r1 = out_s1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_s0 !== '0 || out_s1 !== '0) begin n_fail++; $display("FAIL rst_out_s got %h/%h want 0", out_s0, out_s1); end
    n_cmp++; if (sb_in0 !== 4'h0 || sb_in1 !== 4'h0) begin n_fail++; $display("FAIL rst_sb_in got %h/%h want 0", sb_in0, sb_in1); end
`ifndef SBOX_EXT_GUARDS_EN
    n_cmp++; if (sb_guards !== 2'b01) begin n_fail++; $display("FAIL rst_guards got %b want 01", sb_guards); end
`endif
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    logic [W-1:0] r0, r1;
    do_txn(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, lat, r0, r1);
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, EXP_LAT); end
    n_cmp++; if (r0 !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL basic_s0 got %h want 0123456789abcdef", r0); end
    n_cmp++; if (r1 !== 64'hFFFF0000FFFF0000) begin n_fail++; $display("FAIL basic_s1 got %h want ffff0000ffff0000", r1); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] r0, r1;
    do_txn(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, lat, r0, r1);
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, EXP_LAT); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, out_valid); end
      n_cmp++; if (out_s0 !== r0 || out_s1 !== r1) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %h/%h want %h/%h", i, out_s0, out_s1, r0, r1); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
    end
    consume();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_lfsr();
    logic [15:0] l = 16'hACE1;
    logic [W-1:0] s0 = rnd_state();
    logic [W-1:0] s1 = rnd_state();
    int w = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
`ifndef SBOX_EXT_GUARDS_EN
      n_cmp++; if (sb_guards !== l[1:0]) begin n_fail++; $display("FAIL lfsr_idle_pre got %b want %b", sb_guards, l[1:0]); end
`endif
      step();
    end
    in_s0 = s0;
    in_s1 = s1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
`ifndef SBOX_EXT_GUARDS_EN
      n_cmp++; if (sb_guards !== l[1:0]) begin n_fail++; $display("FAIL lfsr_feed cyc %0d got %b want %b", i, sb_guards, l[1:0]); end
`endif
      n_cmp++; if (sb_in0 !== s0[4*i +: 4] || sb_in1 !== s1[4*i +: 4]) begin n_fail++; $display("FAIL feed_nibble %0d got %h/%h want %h/%h", i, sb_in0, sb_in1, s0[4*i +: 4], s1[4*i +: 4]); end
      l = lfsr_step(l);
      step();
    end
    n_cmp++; if (sb_in0 !== 4'h0 || sb_in1 !== 4'h0) begin n_fail++; $display("FAIL drain_sb_in got %h/%h want 0", sb_in0, sb_in1); end
    while (!out_valid && w < 20) begin step(); w++; end
    n_cmp++; if (out_s0 !== s0 || out_s1 !== s1) begin n_fail++; $display("FAIL lfsr_txn_data got %h/%h want %h/%h", out_s0, out_s1, s0, s1); end
    consume();
    for (int i = 0; i < 3; i++) begin
`ifndef SBOX_EXT_GUARDS_EN
      n_cmp++; if (sb_guards !== l[1:0]) begin n_fail++; $display("FAIL lfsr_idle_post got %b want %b", sb_guards, l[1:0]); end
`endif
      step();
    end
  endtask

  task automatic test_abort();
    int lat;
    bit seen = 1'b0;
    logic [W-1:0] r0, r1;
    logic [W-1:0] s0 = rnd_state();
    logic [W-1:0] s1 = rnd_state();
    in_s0 = s0;
    in_s1 = s1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    n_cmp++; if (sb_in0 !== s0[31:28]) begin n_fail++; $display("FAIL abort_cnt7 got %h want %h", sb_in0, s0[31:28]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_in_rst got rdy=%b vld=%b want 0/0", in_ready, out_valid); end
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_rst2 got %b want 0", in_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_output got %b want 0", seen); end
    s0 = rnd_state();
    s1 = rnd_state();
    do_txn(s0, s1, lat, r0, r1);
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL abort_fresh_latency got %0d want %0d", lat, EXP_LAT); end
    n_cmp++; if (r0 !== s0 || r1 !== s1) begin n_fail++; $display("FAIL abort_fresh_data got %h/%h want %h/%h", r0, r1, s0, s1); end
    consume();
  endtask

  task automatic test_random_sbox();
    int lat;
    logic [W-1:0] r0, r1, s0, s1;
    sb_mode = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      s0 = rnd_state();
      s1 = rnd_state();
      do_txn(s0, s1, lat, r0, r1);
      n_cmp++; if ((r0 ^ r1) !== sbox_state(s0 ^ s1) || lat != EXP_LAT) begin
        n_fail++; $display("FAIL sbox_rand #%0d got %h lat %0d want %h lat %0d", t, r0 ^ r1, lat, sbox_state(s0 ^ s1), EXP_LAT);
      end
      consume();
    end
    sb_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q0[$], q1[$];
    logic [W-1:0] e0, e1;
    int acc_t[$];
    int n_out = 0;
    in_s0 = rnd_state();
    in_s1 = rnd_state();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (in_ready) begin
        acc_t.push_back(t);
        q0.push_back(in_s0);
        q1.push_back(in_s1);
      end
      if (out_valid) begin
        n_out++;
        e0 = (q0.size() > 0) ? q0.pop_front() : '0;
        e1 = (q1.size() > 0) ? q1.pop_front() : '0;
        n_cmp++; if (out_s0 !== e0 || out_s1 !== e1) begin n_fail++; $display("FAIL b2b_data t=%0d got %h/%h want %h/%h", t, out_s0, out_s1, e0, e1); end
      end
      if (t == 59) in_valid = 1'b0;
      step();
      in_s0 = rnd_state();
      in_s1 = rnd_state();
    end
    out_ready = 1'b0;
    n_cmp++; if (acc_t.size() != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", acc_t.size()); end
    n_cmp++; if (n_out != 3) begin n_fail++; $display("FAIL b2b_outputs got %0d want 3", n_out); end
    for (int i = 0; i < acc_t.size(); i++) begin
      n_cmp++; if (acc_t[i] != i * (EXP_LAT + 1)) begin n_fail++; $display("FAIL b2b_accept_time #%0d got %0d want %0d", i, acc_t[i], i * (EXP_LAT + 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_lfsr();
    test_abort();
    test_random_sbox();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
